// File: rtl/stride_seq_pkg.sv
// Shared constants for the stride layer sequencer: FSM state encodings,
// command field layout, error codes and the channel-count ceiling.
package stride_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int CMD_W       = 20;
  localparam int CMD_EN_BIT  = 19;
  localparam int CMD_ROW_LSB = 8;
  localparam int CMD_CH_LSB  = 0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_BEATS   = 2'b10;

  localparam logic [7:0] MAX_CH = 8'd56;

endpackage

// File: rtl/stride_cfg_check.sv
// Combinational validation of a layer command. Splits the command into its
// fields, flags illegal combinations and derives the effective output row
// count r and the number of 8-channel groups (ch_times).
module stride_cfg_check
  import stride_seq_pkg::*;
#(
  parameter int ROW_W = 11,
  parameter int CH_W  = 8
) (
  input  logic [CMD_W-1:0] cmd,
  output logic             cmd_ok,
  output logic             en_stride,
  output logic [ROW_W-1:0] row_num,
  output logic [CH_W-1:0]  ch_num,
  output logic [ROW_W-1:0] r,
  output logic [2:0]       ch_times
);

  // Field extraction, legality checks and derived sizes
  always_comb begin
    en_stride = cmd[CMD_EN_BIT];
    row_num   = cmd[CMD_ROW_LSB +: ROW_W];
    ch_num    = cmd[CMD_CH_LSB +: CH_W];
    cmd_ok    = (ch_num != 8'd0) && (ch_num[2:0] == 3'd0) && (ch_num <= MAX_CH) &&
                (row_num != 11'd0) && (!en_stride || (row_num[0] == 1'b0));
    if (en_stride) begin
      r = row_num >> 1;
    end else begin
      r = row_num;
    end
    ch_times  = ch_num[5:3];
  end

endmodule

// File: rtl/stride_layer_sequencer.sv
// Per-layer controller for the image stride stage: accepts and validates
// layer commands, drives the stage's held config registers and Start pulse,
// tracks input completion and output drain, and checks the output beat count.
// Optional build macro STRIDE_SEQ_PERF_EN adds the Perf_Cycles counter port.
module stride_layer_sequencer
  import stride_seq_pkg::*;
#(
  parameter int ROW_W  = 11,
  parameter int CH_W   = 8,
  parameter int BEAT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [19:0]      Cmd_Data,
  output logic             Start,
  output logic             EN_Stride_REG,
  output logic [ROW_W-1:0] Row_Num_Out_REG,
  output logic [CH_W-1:0]  Channel_Out_Num_REG,
  input  logic             Stride_Complete,
  input  logic             M_Valid,
  input  logic             M_Ready,
  input  logic             Img_Last,
  output logic             Busy,
  output logic             Layer_Done,
  output logic             Err,
  output logic [1:0]       Err_Code
`ifdef STRIDE_SEQ_PERF_EN
  ,
  output logic [31:0]      Perf_Cycles
`endif
);

  logic [2:0]        state_q, state_d;
  logic              setup_cnt_q, setup_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              layer_done_q, layer_done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              en_stride_q, en_stride_d;
  logic [ROW_W-1:0]  row_num_q, row_num_d;
  logic [CH_W-1:0]   ch_num_q, ch_num_d;
  logic [ROW_W-1:0]  r_q, r_d;
  logic [2:0]        ch_times_q, ch_times_d;
  logic [BEAT_W-1:0] exp_beats_q, exp_beats_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              in_done_q, in_done_d;
  logic              out_done_q, out_done_d;

  logic              chk_ok_s;
  logic              chk_en_s;
  logic [ROW_W-1:0]  chk_row_s;
  logic [CH_W-1:0]   chk_ch_s;
  logic [ROW_W-1:0]  chk_r_s;
  logic [2:0]        chk_times_s;
  logic              cmd_accept_s;
  logic              beat_fire_s;

  stride_cfg_check #(.ROW_W(ROW_W), .CH_W(CH_W)) u_cfg_check (
    .cmd       (Cmd_Data),
    .cmd_ok    (chk_ok_s),
    .en_stride (chk_en_s),
    .row_num   (chk_row_s),
    .ch_num    (chk_ch_s),
    .r         (chk_r_s),
    .ch_times  (chk_times_s)
  );

  assign cmd_accept_s = Cmd_Valid && cmd_ready_q;
  assign beat_fire_s  = M_Valid && M_Ready;

  // Next-state and next-output logic of the layer FSM
  always_comb begin
    state_d      = state_q;
    setup_cnt_d  = setup_cnt_q;
    start_d      = 1'b0;
    layer_done_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    en_stride_d  = en_stride_q;
    row_num_d    = row_num_q;
    ch_num_d     = ch_num_q;
    r_d          = r_q;
    ch_times_d   = ch_times_q;
    exp_beats_d  = exp_beats_q;
    beat_cnt_d   = beat_cnt_q;
    in_done_d    = in_done_q;
    out_done_d   = out_done_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_s) begin
          if (chk_ok_s) begin
            en_stride_d = chk_en_s;
            row_num_d   = chk_row_s;
            ch_num_d    = chk_ch_s;
            r_d         = chk_r_s;
            ch_times_d  = chk_times_s;
            beat_cnt_d  = {BEAT_W{1'b0}};
            in_done_d   = 1'b0;
            out_done_d  = 1'b0;
            err_code_d  = ERR_NONE;
            setup_cnt_d = 1'b0;
            state_d     = ST_SETUP;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CMD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // Two settle cycles; the product is recomputed in both, which is harmless.
        exp_beats_d = BEAT_W'(r_q) * BEAT_W'(r_q) * BEAT_W'(ch_times_q);
        if (setup_cnt_q) begin
          setup_cnt_d = 1'b0;
          start_d     = 1'b1;
          state_d     = ST_START;
        end else begin
          setup_cnt_d = 1'b1;
        end
      end
      ST_START: begin
        // The stage never reports input completion in bypass mode.
        in_done_d = !en_stride_q;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (Stride_Complete) begin
          in_done_d = 1'b1;
        end else begin
          in_done_d = in_done_q;
        end
        if (beat_fire_s) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (Img_Last) begin
            out_done_d = 1'b1;
          end else begin
            out_done_d = out_done_q;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        // Judge with the next count so a beat in the exit cycle is included.
        if (in_done_q && out_done_q) begin
          state_d = ST_DONE;
          if (beat_cnt_d == exp_beats_q) begin
            layer_done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BEATS;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, config and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      setup_cnt_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      en_stride_q  <= 1'b0;
      row_num_q    <= {ROW_W{1'b0}};
      ch_num_q     <= {CH_W{1'b0}};
      r_q          <= {ROW_W{1'b0}};
      ch_times_q   <= 3'd0;
      exp_beats_q  <= {BEAT_W{1'b0}};
      beat_cnt_q   <= {BEAT_W{1'b0}};
      in_done_q    <= 1'b0;
      out_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      setup_cnt_q  <= setup_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      layer_done_q <= layer_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      en_stride_q  <= en_stride_d;
      row_num_q    <= row_num_d;
      ch_num_q     <= ch_num_d;
      r_q          <= r_d;
      ch_times_q   <= ch_times_d;
      exp_beats_q  <= exp_beats_d;
      beat_cnt_q   <= beat_cnt_d;
      in_done_q    <= in_done_d;
      out_done_q   <= out_done_d;
    end
  end

  assign Cmd_Ready           = cmd_ready_q;
  assign Busy                = busy_q;
  assign Start               = start_q;
  assign Layer_Done          = layer_done_q;
  assign Err                 = err_q;
  assign Err_Code            = err_code_q;
  assign EN_Stride_REG       = en_stride_q;
  assign Row_Num_Out_REG     = row_num_q;
  assign Channel_Out_Num_REG = ch_num_q;

`ifdef STRIDE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of START and RUN cycles, cleared when a layer is accepted
  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && cmd_accept_s && chk_ok_s) begin
      perf_d = 32'd0;
    end else if (((state_q == ST_START) || (state_q == ST_RUN)) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign Perf_Cycles = perf_q;
`endif

endmodule

// File: tb/tb_stride_layer_sequencer.sv
// Directed self-checking bench for stride_layer_sequencer.
module tb_stride_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Cmd_Valid = 1'b0;
  logic        Cmd_Ready;
  logic [19:0] Cmd_Data = 20'd0;
  logic        Start;
  logic        EN_Stride_REG;
  logic [10:0] Row_Num_Out_REG;
  logic [7:0]  Channel_Out_Num_REG;
  logic        Stride_Complete = 1'b0;
  logic        M_Valid = 1'b0;
  logic        M_Ready = 1'b0;
  logic        Img_Last = 1'b0;
  logic        Busy;
  logic        Layer_Done;
  logic        Err;
  logic [1:0]  Err_Code;
`ifdef STRIDE_SEQ_PERF_EN
  logic [31:0] Perf_Cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stride_layer_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .Cmd_Valid           (Cmd_Valid),
    .Cmd_Ready           (Cmd_Ready),
    .Cmd_Data            (Cmd_Data),
    .Start               (Start),
    .EN_Stride_REG       (EN_Stride_REG),
    .Row_Num_Out_REG     (Row_Num_Out_REG),
    .Channel_Out_Num_REG (Channel_Out_Num_REG),
    .Stride_Complete     (Stride_Complete),
    .M_Valid             (M_Valid),
    .M_Ready             (M_Ready),
    .Img_Last            (Img_Last),
    .Busy                (Busy),
    .Layer_Done          (Layer_Done),
    .Err                 (Err),
    .Err_Code            (Err_Code)
`ifdef STRIDE_SEQ_PERF_EN
    ,
    .Perf_Cycles         (Perf_Cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle while the sequencer is idle.
  task automatic send_cmd(input logic en, input logic [10:0] rows, input logic [7:0] ch);
    Cmd_Valid = 1'b1;
    Cmd_Data  = {en, rows, ch};
    tick();
    Cmd_Valid = 1'b0;
  endtask

  // Called right after a valid accept: Start must pulse in the third cycle.
  task automatic check_start(input string tag);
    chk({tag, "_busy"},   32'(Busy), 32'd1);
    chk({tag, "_start0"}, 32'(Start), 32'd0);
    tick();
    chk({tag, "_start1"}, 32'(Start), 32'd0);
    tick();
    chk({tag, "_start2"}, 32'(Start), 32'd1);
    tick();
    chk({tag, "_start3"}, 32'(Start), 32'd0);
  endtask

  // One output cycle on the stride output port.
  task automatic beat(input logic last, input logic sc);
    M_Valid = 1'b1; M_Ready = 1'b1; Img_Last = last; Stride_Complete = sc;
    tick();
    M_Valid = 1'b0; M_Ready = 1'b0; Img_Last = 1'b0; Stride_Complete = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(Cmd_Ready), 32'd1);
    chk("rst_busy",  32'(Busy), 32'd0);
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_cfg",   {12'd0, EN_Stride_REG, Row_Num_Out_REG, Channel_Out_Num_REG}, 32'd0);
    chk("rst_err",   {29'd0, Err, Err_Code}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: stride on, 4 rows, 16 ch -> 2*2*2 = 8 beats
    send_cmd(1'b1, 11'd4, 8'd16);
    chk("t1_cfg", {12'd0, EN_Stride_REG, Row_Num_Out_REG, Channel_Out_Num_REG}, {12'd0, 1'b1, 11'd4, 8'd16});
    chk("t1_ready", 32'(Cmd_Ready), 32'd0);
    check_start("t1");
    Stride_Complete = 1'b1;
    tick();
    Stride_Complete = 1'b0;
    for (int i = 0; i < 8; i++) beat(i == 7, 1'b0);
    chk("t1_pre_done", 32'(Layer_Done), 32'd0);
    tick();
    chk("t1_done", 32'(Layer_Done), 32'd1);
    chk("t1_err",  32'(Err), 32'd0);
`ifdef STRIDE_SEQ_PERF_EN
    chk("t1_perf", Perf_Cycles, 32'd11);
`endif
    tick();
    chk("t1_idle", {30'd0, Busy, Cmd_Ready}, 32'd1);
    chk("t1_done_pulse", 32'(Layer_Done), 32'd0);

    // T2: bypass, 3 rows, 8 ch -> 9 beats, no Stride_Complete; a stalled beat is not counted
    send_cmd(1'b0, 11'd3, 8'd8);
    check_start("t2");
    M_Valid = 1'b1; M_Ready = 1'b0; Img_Last = 1'b1;
    tick();
    M_Valid = 1'b0; Img_Last = 1'b0;
    for (int i = 0; i < 9; i++) beat(i == 8, 1'b0);
    tick();
    chk("t2_done", 32'(Layer_Done), 32'd1);
    chk("t2_err",  32'(Err), 32'd0);
    tick();
    chk("t2_busy", 32'(Busy), 32'd0);

    // T3: rejected commands (odd rows with stride, ch not multiple of 8, ch above 56)
    send_cmd(1'b1, 11'd5, 8'd16);
    chk("t3a_err",  {29'd0, Err, Err_Code}, 32'd5);
    chk("t3a_busy", {30'd0, Busy, Cmd_Ready}, 32'd1);
    chk("t3a_cfg",  {12'd0, EN_Stride_REG, Row_Num_Out_REG, Channel_Out_Num_REG}, {12'd0, 1'b0, 11'd3, 8'd8});
    tick();
    chk("t3a_pulse", {29'd0, Err, Err_Code}, 32'd1);
    send_cmd(1'b0, 11'd4, 8'd12);
    chk("t3b_err", {29'd0, Err, Err_Code}, 32'd5);
    send_cmd(1'b0, 11'd1, 8'd64);
    chk("t3c_err", {29'd0, Err, Err_Code}, 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("t3_nostart", {30'd0, Start, Busy}, 32'd0);
      tick();
    end

    // T4: stride on, 4 rows, 8 ch -> expects 4 beats, last arrives on 3rd
    send_cmd(1'b1, 11'd4, 8'd8);
    chk("t4_code_clr", 32'(Err_Code), 32'd0);
    check_start("t4");
    Stride_Complete = 1'b1;
    tick();
    Stride_Complete = 1'b0;
    for (int i = 0; i < 3; i++) beat(i == 2, 1'b0);
    tick();
    chk("t4_err",  {29'd0, Err, Err_Code}, 32'd6);
    chk("t4_done", 32'(Layer_Done), 32'd0);
    tick();
    chk("t4_hold", {29'd0, Err, Err_Code}, 32'd2);

    // T5: stride on, 2 rows, 8 ch -> 1 beat, Stride_Complete in the same cycle
    send_cmd(1'b1, 11'd2, 8'd8);
    check_start("t5");
    beat(1'b1, 1'b1);
    chk("t5_pre", 32'(Layer_Done), 32'd0);
    Cmd_Valid = 1'b1;
    Cmd_Data  = {1'b0, 11'd2, 8'd16};
    tick();
    chk("t5_done", {30'd0, Layer_Done, Cmd_Ready}, 32'd2);
    tick();
    chk("t5_ready", {30'd0, Cmd_Ready, Busy}, 32'd2);
    tick();
    Cmd_Valid = 1'b0;
    chk("t5_b2b_cfg", {12'd0, EN_Stride_REG, Row_Num_Out_REG, Channel_Out_Num_REG}, {12'd0, 1'b0, 11'd2, 8'd16});
    check_start("t5b");

    // T6: reset while running
    beat(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_state", {30'd0, Cmd_Ready, Busy}, 32'd2);
    chk("t6_cfg",   {12'd0, EN_Stride_REG, Row_Num_Out_REG, Channel_Out_Num_REG}, 32'd0);
    chk("t6_flags", {28'd0, Start, Layer_Done, Err_Code}, 32'd0);
    // Completion events outside RUN are ignored
    beat(1'b1, 1'b1);
    tick();
    chk("t6_ignore", {28'd0, Busy, Layer_Done, Err, Start}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
